// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler that shares one serial frame transmitter among N_REQ requesters,
// timing each frame internally and enforcing an idle gap before the next grant.
module tx_frame_scheduler #(
  parameter int N_REQ        = 4,
  parameter int FRAME_CYCLES = 3002,
  parameter int GAP_CYCLES   = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               done,
  output logic [2:0]         cur_id
);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  state_t            state;
  logic [15:0]       cnt;
  logic [2:0]        rr_ptr;

  logic              found;
  logic [2:0]        win;
  int                idx;
  logic [N_REQ-1:0]  req_sh;
  logic [7:0]        win_data;
  logic [N_REQ-1:0]  win_onehot;
  logic [2:0]        nxt_ptr;

  // Scan requesters starting at rr_ptr; the first one found wins.
  always_comb begin
    found  = 1'b0;
    win    = 3'd0;
    idx    = 0;
    req_sh = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      req_sh = req >> idx;
      if (!found && req_sh[0]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  assign win_data   = 8'(req_data >> {win, 3'b000});
  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win;
  assign nxt_ptr    = (win == 3'(N_REQ-1)) ? 3'd0 : win + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ack      <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      cur_id   <= 3'd0;
      rr_ptr   <= 3'd0;
      cnt      <= 16'd0;
    end else begin
      ack      <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && found) begin
            state    <= START;
            tx_data  <= win_data;
            ack      <= win_onehot;
            tx_start <= 1'b1;
            cur_id   <= win;
            rr_ptr   <= nxt_ptr;
            cnt      <= 16'd0;
            busy     <= 1'b1;
          end
        end
        START: begin
          // A one-clock frame ends in START itself.
          if (cnt == 16'(FRAME_CYCLES-1)) begin
            state <= GAP;
            done  <= 1'b1;
            cnt   <= 16'd0;
          end else begin
            state <= SEND;
            cnt   <= 16'd1;
          end
        end
        SEND: begin
          if (cnt == 16'(FRAME_CYCLES-1)) begin
            state <= GAP;
            done  <= 1'b1;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == 16'(GAP_CYCLES-1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
